if_fetch_stage: RTL and testbench

- Instruction-fetch pipeline stage; the producer end of the IF/ID interface that the decode stage consumes.
- Owns the PC and talks to instruction memory over a req/gnt, rvalid handshake with at most one request outstanding.
- Drives Instruction_id and PC_id into decode.
- Obeys decode's IFWrite (hazard hold), and its Branch, Jump and JumpAddr (redirect).

---
 rtl/if_pkg.sv | 17 +
 rtl/if_fetch_stage_if.sv | 13 +
 rtl/if_id_reg.sv | 32 +++
 rtl/if_fetch_stage.sv | 158 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package if_pkg;
  localparam int          INST_W      = 32;
  localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    FULL = 2'd3
  } if_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus: req/gnt handshake, rvalid response.
interface if_fetch_stage_if;
  import if_pkg::*;

  logic              req;
  logic [31:0]       addr;
  logic              gnt;
  logic              rvalid;
  logic [INST_W-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register pair; flush and bubble insertion both load NOP with PC 0.
module if_id_reg
  import if_pkg::*;
#(
  parameter int                DATA_W   = INST_W,
  parameter logic [DATA_W-1:0] NOP_INST = IF_NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flush,
  input  logic              nop_ins,
  input  logic [DATA_W-1:0] inst_d,
  input  logic [DATA_W-1:0] pc_d,
  output logic [DATA_W-1:0] inst_q,
  output logic [DATA_W-1:0] pc_q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      inst_q <= NOP_INST;
      pc_q   <= '0;
    end else if (load) begin
      inst_q <= inst_d;
      pc_q   <= pc_d;
    end else if (nop_ins) begin
      inst_q <= NOP_INST;
      pc_q   <= '0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over imem with one request in flight.
// Optional IF_PERF_COUNT_EN adds fetch_cnt/bubble_cnt performance counters.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IFWrite,
  input  logic              Branch,
  input  logic              Jump,
  input  logic [31:0]       JumpAddr,
  if_fetch_stage_if.master  imem,
  output logic [INST_W-1:0] Instruction_id,
  output logic [31:0]       PC_id
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  if_state_e         state;
  logic [31:0]       pc;
  logic [INST_W-1:0] buffer;

  logic              redir;
  logic [31:0]       pc_plus4;
  logic [31:0]       target;
  logic              req_c;
  logic [31:0]       addr_c;
  logic              id_load;
  logic              id_flush;
  logic              id_nop;
  logic [INST_W-1:0] id_inst;

  assign redir    = IFWrite & (Branch | Jump);
  assign pc_plus4 = pc + 32'd4;
  assign target   = align_word(JumpAddr);

  // The request is combinational so a response in WAIT can launch the next fetch in the same cycle.
  always_comb begin
    req_c    = 1'b0;
    addr_c   = pc;
    id_load  = 1'b0;
    id_flush = 1'b0;
    id_nop   = 1'b0;
    id_inst  = imem.rdata;
    case (state)
      REQ: begin
        req_c = 1'b1;
        if (redir)        id_flush = 1'b1;
        else if (IFWrite) id_nop   = 1'b1;
      end
      WAIT: begin
        if (redir) begin
          id_flush = 1'b1;
        end else if (imem.rvalid && IFWrite) begin
          id_load = 1'b1;
          req_c   = 1'b1;
          addr_c  = pc_plus4;
        end else if (!imem.rvalid && IFWrite) begin
          id_nop = 1'b1;
        end
      end
      FULL: begin
        id_inst = buffer;
        if (redir)        id_flush = 1'b1;
        else if (IFWrite) id_load  = 1'b1;
      end
      DROP: begin
        if (redir)        id_flush = 1'b1;
        else if (IFWrite) id_nop   = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem.req  = req_c & ~reset;
  assign imem.addr = align_word(addr_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= REQ;
      pc     <= RESET_PC;
      buffer <= '0;
    end else begin
      case (state)
        REQ: begin
          if (redir) begin
            pc    <= target;
            state <= imem.gnt ? DROP : REQ;
          end else if (imem.gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redir) begin
            pc    <= target;
            state <= imem.rvalid ? REQ : DROP;
          end else if (imem.rvalid) begin
            if (IFWrite) begin
              pc    <= pc_plus4;
              state <= imem.gnt ? WAIT : REQ;
            end else begin
              buffer <= imem.rdata;
              state  <= FULL;
            end
          end
        end
        FULL: begin
          if (redir) begin
            pc    <= target;
            state <= REQ;
          end else if (IFWrite) begin
            pc    <= pc_plus4;
            state <= REQ;
          end
        end
        DROP: begin
          if (redir)       pc    <= target;
          if (imem.rvalid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  if_id_reg #(
    .DATA_W   (INST_W),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (id_load),
    .flush   (id_flush),
    .nop_ins (id_nop),
    .inst_d  (id_inst),
    .pc_d    (pc),
    .inst_q  (Instruction_id),
    .pc_q    (PC_id)
  );

`ifdef IF_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (id_load)                         fetch_cnt  <= fetch_cnt + 32'd1;
      if (IFWrite && (id_flush || id_nop)) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: memory model, address/IF-ID monitors, directed scenarios.
module tb_if_fetch_stage;
  import if_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        IFWrite;
  logic        Branch;
  logic        Jump;
  logic [31:0] JumpAddr;
  logic [31:0] Instruction_id;
  logic [31:0] PC_id;
`ifdef IF_PERF_COUNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_fetch_stage_if imem_bus();

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_id_q[$];

  bit gnt_mode = 1'b1;
  int lat      = 1;
  bit mon_en   = 1'b0;
  bit late_ok  = 1'b0;

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .IFWrite        (IFWrite),
    .Branch         (Branch),
    .Jump           (Jump),
    .JumpAddr       (JumpAddr),
    .imem           (imem_bus),
    .Instruction_id (Instruction_id),
    .PC_id          (PC_id)
`ifdef IF_PERF_COUNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_inst(input logic [31:0] a);
    exp_id_q.push_back({mem_word(a), a});
  endtask

  // Memory model: grants per gnt_mode, answers each grant after lat cycles.
  initial begin
    bit          pend;
    logic [31:0] paddr;
    int          cnt;
    pend  = 1'b0;
    paddr = '0;
    cnt   = 0;
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    forever begin
      @(posedge clk);
      #3;
      imem_bus.rvalid = 1'b0;
      imem_bus.gnt    = gnt_mode;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata  = mem_word(paddr);
          pend = 1'b0;
        end
      end
      @(negedge clk);
      if (imem_bus.req && imem_bus.gnt) begin
        checks++;
        if (pend) begin
          errors++;
          $display("FAIL overlap: grant for %h while %h still outstanding", imem_bus.addr, paddr);
        end
        pend  = 1'b1;
        paddr = imem_bus.addr;
        cnt   = lat;
      end
    end
  end

  // Monitor: granted addresses and each new real IF/ID entry are popped against the queues.
  initial begin
    logic [63:0] prev;
    logic [63:0] cur;
    logic [63:0] e;
    prev = {NOP, 32'h0};
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (imem_bus.req && imem_bus.gnt) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL imem_addr: unexpected grant of %h, none required", imem_bus.addr);
          end else begin
            chk("imem_addr", imem_bus.addr, exp_addr_q.pop_front());
          end
        end
        cur = {Instruction_id, PC_id};
        if (cur != prev && Instruction_id != NOP) begin
          if (exp_id_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL if_id: unexpected entry inst %h pc %h, none required", Instruction_id, PC_id);
          end else begin
            e = exp_id_q.pop_front();
            chk("Instruction_id", Instruction_id, e[63:32]);
            chk("PC_id", PC_id, e[31:0]);
          end
        end
        prev = cur;
        if (imem_bus.rvalid && !late_ok) begin
          checks++;
          if (dut.state == REQ || dut.state == FULL) begin
            errors++;
            $display("FAIL protocol: rvalid in state %0d, required WAIT or DROP", dut.state);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    IFWrite  = 1'b1;
    Branch   = 1'b0;
    Jump     = 1'b0;
    JumpAddr = '0;
    tick();
    tick();
    chk("reset_inst", Instruction_id, NOP);
    chk("reset_pc_id", PC_id, 32'h0);
    chk("reset_req", {31'b0, imem_bus.req}, 32'h0);

    // Streaming from reset, then a 2-cycle hold while the response for 12 arrives.
    push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h8); push_fetch(32'hC); push_fetch(32'h10);
    push_inst(32'h0);  push_inst(32'h4);  push_inst(32'h8);  push_inst(32'hC);
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    tick(); tick(); tick();
    tick();
    IFWrite = 1'b0;
    chk("hold_inst_a", Instruction_id, mem_word(32'h8));
    chk("hold_pc_a", PC_id, 32'h8);
    tick();
    chk("hold_no_req", {31'b0, imem_bus.req}, 32'h0);
    chk("hold_inst_b", Instruction_id, mem_word(32'h8));
    chk("hold_pc_b", PC_id, 32'h8);
    tick();
    IFWrite = 1'b1;
    lat     = 2;
    tick();

    // Jump to 0x101 (aligned 0x100) while the fetch of 0x10 is outstanding.
    tick();
    Jump     = 1'b1;
    JumpAddr = 32'h0000_0101;
    lat      = 1;
    push_fetch(32'h100); push_fetch(32'h104); push_fetch(32'h108);
    push_inst(32'h100);  push_inst(32'h104);
    tick();
    Jump = 1'b0;
    chk("jump_flush_inst", Instruction_id, NOP);
    chk("jump_flush_pc", PC_id, 32'h0);
    chk("drop_no_req", {31'b0, imem_bus.req}, 32'h0);
    tick();
    chk("jump_addr", imem_bus.addr, 32'h100);
    chk("jump_req", {31'b0, imem_bus.req}, 32'h1);
    tick(); tick();

    // Branch under hold is ignored, then taken once IFWrite returns.
    tick();
    IFWrite  = 1'b0;
    Branch   = 1'b1;
    JumpAddr = 32'h200;
    tick();
    IFWrite  = 1'b1;
    gnt_mode = 1'b0;
    chk("br_hold_no_req", {31'b0, imem_bus.req}, 32'h0);
    chk("br_hold_inst", Instruction_id, mem_word(32'h104));
    chk("br_hold_pc", PC_id, 32'h104);
    tick();
    Branch = 1'b0;
    chk("br_flush_inst", Instruction_id, NOP);
    chk("br_flush_pc", PC_id, 32'h0);
    chk("br_req", {31'b0, imem_bus.req}, 32'h1);
    chk("br_addr", imem_bus.addr, 32'h200);

    // Grant withheld, then redirect to 0x40 before the 0x200 request is accepted.
    tick();
    chk("nognt_req", {31'b0, imem_bus.req}, 32'h1);
    chk("nognt_addr", imem_bus.addr, 32'h200);
    tick();
    tick();
    Jump     = 1'b1;
    JumpAddr = 32'h40;
    push_fetch(32'h40); push_fetch(32'h44); push_fetch(32'h48);
    push_inst(32'h40);  push_inst(32'h44);
    tick();
    Jump     = 1'b0;
    gnt_mode = 1'b1;
    chk("retarget_addr", imem_bus.addr, 32'h40);
    chk("retarget_req", {31'b0, imem_bus.req}, 32'h1);
    tick();
    tick();
    lat = 2;

    // Reset while the fetch of 0x48 is pending; its late response must be ignored.
    tick();
    reset   = 1'b1;
    late_ok = 1'b1;
    push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h8); push_fetch(32'hC);
    push_inst(32'h0);  push_inst(32'h4);  push_inst(32'h8);  push_inst(32'hC);
    #1;
    chk("rst_mid_req", {31'b0, imem_bus.req}, 32'h0);
    tick();
    reset = 1'b0;
    lat   = 1;
    #1;
    chk("rst_mid_inst", Instruction_id, NOP);
    chk("rst_mid_pc_id", PC_id, 32'h0);
    chk("rst_mid_req_on", {31'b0, imem_bus.req}, 32'h1);
    chk("rst_mid_addr", imem_bus.addr, 32'h0);
    tick();
    late_ok = 1'b0;
    tick(); tick();
    tick();
    gnt_mode = 1'b0;
    repeat (4) tick();

    chk("addr_q_left", 32'(exp_addr_q.size()), 32'h0);
    chk("id_q_left", 32'(exp_id_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
